// File: rtl/vend_sequencer.sv
// Single-product vend controller: coin credit, vend and change handshakes.
// Optional refund-on-cancel enabled by defining VEND_CANCEL_EN.
module vend_sequencer #(
  parameter int PRICE    = 4,
  parameter int CREDIT_W = 5,
  parameter int CNT_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                nickel,
  input  logic                dime,
  input  logic                quarter,
`ifdef VEND_CANCEL_EN
  input  logic                cancel,
`endif
  input  logic                vend_ack,
  input  logic                chg_ack,
  output logic                vend_req,
  output logic                chg_req,
  output logic                coin_reject,
  output logic [CREDIT_W-1:0] credit,
  output logic [CNT_W-1:0]    sales_count,
  output logic [2:0]          state_check
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCUM  = 3'd1,
    VEND   = 3'd2,
    CHANGE = 3'd3
  } state_e;

  localparam logic [CREDIT_W-1:0] PRICE_C = PRICE[CREDIT_W-1:0];

  state_e              state_q;
  logic [CREDIT_W-1:0] credit_q;
  logic [CNT_W-1:0]    sales_q;
  logic                reject_q;

  logic [2:0]          coin_val;
  logic                coin_any;
  logic                coin_multi;
  logic                cancel_w;
  logic [CREDIT_W:0]   sum_d;
  logic                accepting;

`ifdef VEND_CANCEL_EN
  assign cancel_w = cancel;
`else
  assign cancel_w = 1'b0;
`endif

  always_comb begin
    coin_val = 3'd0;
    priority case (1'b1)
      quarter: coin_val = 3'd5;
      dime:    coin_val = 3'd2;
      nickel:  coin_val = 3'd1;
      default: coin_val = 3'd0;
    endcase
  end

  assign coin_any   = nickel | dime | quarter;
  assign coin_multi = (nickel & dime) | (nickel & quarter)
                    | (dime & quarter);
  assign sum_d      = {1'b0, credit_q} + (CREDIT_W+1)'(coin_val);
  assign accepting  = (state_q == IDLE) || (state_q == ACCUM);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      credit_q <= '0;
      sales_q  <= '0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      case (state_q)
        IDLE, ACCUM: begin
          if (coin_any) begin
            credit_q <= sum_d[CREDIT_W-1:0];
            reject_q <= coin_multi;
          end
          // Cancel overrides the coin's own routing, even past PRICE.
          if (cancel_w && state_q == ACCUM)
            state_q <= CHANGE;
          else if (coin_any)
            state_q <= (sum_d >= {1'b0, PRICE_C}) ? VEND : ACCUM;
        end
        VEND: begin
          reject_q <= coin_any;
          if (vend_ack) begin
            credit_q <= credit_q - PRICE_C;
            sales_q  <= sales_q + 1'b1;
            state_q  <= (credit_q > PRICE_C) ? CHANGE : IDLE;
          end
        end
        CHANGE: begin
          reject_q <= coin_any;
          if (credit_q == '0) begin
            state_q <= IDLE;
          end else if (chg_ack) begin
            credit_q <= credit_q - 1'b1;
            if (credit_q == CREDIT_W'(1))
              state_q <= IDLE;
          end
        end
        default: begin
          state_q  <= IDLE;
          credit_q <= '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst && accepting && coin_any)
      assert (!sum_d[CREDIT_W])
        else $error("credit overflow");
  end

  assign vend_req    = (state_q == VEND);
  assign chg_req     = (state_q == CHANGE);
  assign coin_reject = reject_q;
  assign credit      = credit_q;
  assign sales_count = sales_q;
  assign state_check = state_q;

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed self-checking bench for vend_sequencer (PRICE=4).
// Each task drives one scenario and checks inline.
module tb_vend_sequencer;

  logic       clk;
  logic       rst;
  logic       nickel;
  logic       dime;
  logic       quarter;
`ifdef VEND_CANCEL_EN
  logic       cancel;
`endif
  logic       vend_ack;
  logic       chg_ack;
  logic       vend_req;
  logic       chg_req;
  logic       coin_reject;
  logic [4:0] credit;
  logic [7:0] sales_count;
  logic [2:0] state_check;

  int n_vec;
  int n_err;
  int exp_sales;

  vend_sequencer #(
    .PRICE(4),
    .CREDIT_W(5),
    .CNT_W(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .nickel(nickel),
    .dime(dime),
    .quarter(quarter),
`ifdef VEND_CANCEL_EN
    .cancel(cancel),
`endif
    .vend_ack(vend_ack),
    .chg_ack(chg_ack),
    .vend_req(vend_req),
    .chg_req(chg_req),
    .coin_reject(coin_reject),
    .credit(credit),
    .sales_count(sales_count),
    .state_check(state_check)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic coin(input logic n, input logic d, input logic q);
    nickel = n; dime = d; quarter = q;
    tick();
    nickel = 0; dime = 0; quarter = 0;
  endtask

  task automatic vack();
    vend_ack = 1; tick(); vend_ack = 0;
  endtask

  task automatic cack();
    chg_ack = 1; tick(); chg_ack = 0;
  endtask

  task automatic test_reset();
    rst = 1; #1 rst = 0; #1;
    n_vec++; if (credit !== 5'd0) begin n_err++; $display("FAIL rst_credit: got %0d required 0", credit); end
    n_vec++; if (state_check !== 3'd0) begin n_err++; $display("FAIL rst_state: got %0d required 0", state_check); end
    n_vec++; if (sales_count !== 8'd0) begin n_err++; $display("FAIL rst_sales: got %0d required 0", sales_count); end
    n_vec++; if ({vend_req, chg_req, coin_reject} !== 3'b000) begin n_err++; $display("FAIL rst_outs: got %b required 000", {vend_req, chg_req, coin_reject}); end
    @(negedge clk); rst = 1;
    exp_sales = 0;
  endtask

  task automatic test_exact_price();
    coin(0, 1, 0);
    n_vec++; if (credit !== 5'd2 || state_check !== 3'd1) begin n_err++; $display("FAIL dd_first: got credit %0d state %0d required 2/1", credit, state_check); end
    coin(0, 1, 0);
    n_vec++; if (credit !== 5'd4 || vend_req !== 1'b1) begin n_err++; $display("FAIL dd_vend: got credit %0d vend_req %b required 4/1", credit, vend_req); end
    tick();
    n_vec++; if (vend_req !== 1'b1 || chg_req !== 1'b0) begin n_err++; $display("FAIL dd_hold: got vend_req %b chg_req %b required 1/0", vend_req, chg_req); end
    vack(); exp_sales++;
    n_vec++; if (credit !== 5'd0 || state_check !== 3'd0 || chg_req !== 1'b0) begin n_err++; $display("FAIL dd_done: got credit %0d state %0d chg %b required 0/0/0", credit, state_check, chg_req); end
    n_vec++; if (sales_count !== 8'(exp_sales)) begin n_err++; $display("FAIL dd_sales: got %0d required %0d", sales_count, exp_sales); end
  endtask

  task automatic test_change();
    coin(1, 0, 0);
    coin(0, 0, 1);
    n_vec++; if (credit !== 5'd6 || state_check !== 3'd2) begin n_err++; $display("FAIL chg_vend: got credit %0d state %0d required 6/2", credit, state_check); end
    vack(); exp_sales++;
    n_vec++; if (credit !== 5'd2 || chg_req !== 1'b1 || state_check !== 3'd3) begin n_err++; $display("FAIL chg_enter: got credit %0d chg %b state %0d required 2/1/3", credit, chg_req, state_check); end
    cack();
    n_vec++; if (credit !== 5'd1 || chg_req !== 1'b1) begin n_err++; $display("FAIL chg_one: got credit %0d chg %b required 1/1", credit, chg_req); end
    cack();
    n_vec++; if (credit !== 5'd0 || chg_req !== 1'b0 || state_check !== 3'd0) begin n_err++; $display("FAIL chg_done: got credit %0d chg %b state %0d required 0/0/0", credit, chg_req, state_check); end
    n_vec++; if (sales_count !== 8'(exp_sales)) begin n_err++; $display("FAIL chg_sales: got %0d required %0d", sales_count, exp_sales); end
  endtask

  task automatic test_reject();
    coin(0, 1, 0);
    coin(0, 1, 0);
    n_vec++; if (coin_reject !== 1'b0) begin n_err++; $display("FAIL rej_none: got %b required 0", coin_reject); end
    coin(0, 1, 0);
    n_vec++; if (coin_reject !== 1'b1 || credit !== 5'd4 || state_check !== 3'd2) begin n_err++; $display("FAIL rej_vend: got rej %b credit %0d state %0d required 1/4/2", coin_reject, credit, state_check); end
    tick();
    n_vec++; if (coin_reject !== 1'b0) begin n_err++; $display("FAIL rej_pulse: got %b required 0", coin_reject); end
    vack(); exp_sales++;
    coin(0, 1, 1);
    n_vec++; if (credit !== 5'd5 || coin_reject !== 1'b1 || state_check !== 3'd2) begin n_err++; $display("FAIL rej_multi: got credit %0d rej %b state %0d required 5/1/2", credit, coin_reject, state_check); end
    vack(); exp_sales++;
    n_vec++; if (credit !== 5'd1 || state_check !== 3'd3) begin n_err++; $display("FAIL rej_rem: got credit %0d state %0d required 1/3", credit, state_check); end
    coin(1, 0, 0);
    n_vec++; if (coin_reject !== 1'b1 || credit !== 5'd1) begin n_err++; $display("FAIL rej_change: got rej %b credit %0d required 1/1", coin_reject, credit); end
    cack();
    n_vec++; if (state_check !== 3'd0 || sales_count !== 8'(exp_sales)) begin n_err++; $display("FAIL rej_end: got state %0d sales %0d required 0/%0d", state_check, sales_count, exp_sales); end
  endtask

  task automatic test_cancel();
    coin(1, 0, 0); coin(1, 0, 0); coin(1, 0, 0);
    n_vec++; if (credit !== 5'd3 || state_check !== 3'd1) begin n_err++; $display("FAIL can_accum: got credit %0d state %0d required 3/1", credit, state_check); end
`ifdef VEND_CANCEL_EN
    cancel = 1; tick(); cancel = 0;
    n_vec++; if (chg_req !== 1'b1 || credit !== 5'd3) begin n_err++; $display("FAIL can_enter: got chg %b credit %0d required 1/3", chg_req, credit); end
    cack(); cack(); cack();
    n_vec++; if (state_check !== 3'd0 || credit !== 5'd0) begin n_err++; $display("FAIL can_done: got state %0d credit %0d required 0/0", state_check, credit); end
`else
    tick(); tick(); tick();
    n_vec++; if (credit !== 5'd3 || state_check !== 3'd1) begin n_err++; $display("FAIL can_hold: got credit %0d state %0d required 3/1", credit, state_check); end
    coin(1, 0, 0);
    vack(); exp_sales++;
    n_vec++; if (state_check !== 3'd0 || credit !== 5'd0) begin n_err++; $display("FAIL can_vend: got state %0d credit %0d required 0/0", state_check, credit); end
`endif
    n_vec++; if (sales_count !== 8'(exp_sales)) begin n_err++; $display("FAIL can_sales: got %0d required %0d", sales_count, exp_sales); end
  endtask

  task automatic test_reset_mid_change();
    coin(1, 0, 0);
    coin(0, 0, 1);
    vack();
    n_vec++; if (credit !== 5'd2 || chg_req !== 1'b1) begin n_err++; $display("FAIL mrst_pre: got credit %0d chg %b required 2/1", credit, chg_req); end
    #2 rst = 0; #1;
    n_vec++; if (credit !== 5'd0 || chg_req !== 1'b0 || state_check !== 3'd0) begin n_err++; $display("FAIL mrst_now: got credit %0d chg %b state %0d required 0/0/0", credit, chg_req, state_check); end
    n_vec++; if (sales_count !== 8'd0) begin n_err++; $display("FAIL mrst_sales: got %0d required 0", sales_count); end
    @(negedge clk); rst = 1;
    exp_sales = 0;
  endtask

  task automatic test_spurious_ack();
    vack();
    cack();
    n_vec++; if (sales_count !== 8'd0 || state_check !== 3'd0 || credit !== 5'd0) begin n_err++; $display("FAIL spur: got sales %0d state %0d credit %0d required 0/0/0", sales_count, state_check, credit); end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 255; i++) begin
      coin(0, 1, 0); coin(0, 1, 0); vack();
    end
    n_vec++; if (sales_count !== 8'd255) begin n_err++; $display("FAIL wrap_255: got %0d required 255", sales_count); end
    coin(0, 1, 0); coin(0, 1, 0); vack();
    n_vec++; if (sales_count !== 8'd0 || state_check !== 3'd0) begin n_err++; $display("FAIL wrap_0: got sales %0d state %0d required 0/0", sales_count, state_check); end
  endtask

  initial begin
    n_vec = 0; n_err = 0; exp_sales = 0;
    nickel = 0; dime = 0; quarter = 0;
    vend_ack = 0; chg_ack = 0;
`ifdef VEND_CANCEL_EN
    cancel = 0;
`endif
    test_reset();
    test_exact_price();
    test_change();
    test_reject();
    test_cancel();
    test_reset_mid_change();
    test_spurious_ack();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
